// File: rtl/vm2002_change_dispenser.sv
// Change dispenser for the vm2002 vending core: pays out a balance coin by coin,
// greedy largest-first against local coin stock, and flags any unreturnable remainder.
module vm2002_change_dispenser #(
  parameter int unsigned NICKEL_VAL  = 5,
  parameter int unsigned DIME_VAL    = 10,
  parameter int unsigned QUARTER_VAL = 25,
  parameter int unsigned STOCK_W     = 8
) (
  input  logic               clk_i,
  input  logic               hrst_i,
  input  logic               bal_valid_i,
  input  logic [7:0]         balance_i,
  output logic               bal_ready_o,
  output logic               coin_valid_o,
  output logic [1:0]         coin_type_o,
  input  logic               coin_ready_i,
  input  logic               stock_load_i,
  input  logic [1:0]         stock_sel_i,
  input  logic [STOCK_W-1:0] stock_val_i,
  output logic [STOCK_W-1:0] stock_n_o,
  output logic [STOCK_W-1:0] stock_d_o,
  output logic [STOCK_W-1:0] stock_q_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               short_o,
  output logic [7:0]         short_amount_o,
  output logic [5:0]         coins_issued_o
);

  localparam logic [7:0] NVal = 8'(NICKEL_VAL);
  localparam logic [7:0] DVal = 8'(DIME_VAL);
  localparam logic [7:0] QVal = 8'(QUARTER_VAL);
  localparam logic [STOCK_W-1:0] StockOne = STOCK_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StIssue,
    StDone,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         remaining_q, remaining_d;
  logic [STOCK_W-1:0] stock_n_q, stock_n_d;
  logic [STOCK_W-1:0] stock_d_q, stock_d_d;
  logic [STOCK_W-1:0] stock_q_q, stock_q_d;
  logic [5:0]         coins_q, coins_d;
  logic [7:0]         short_amt_q, short_amt_d;
  logic               coin_valid_q, coin_valid_d;
  logic [1:0]         coin_type_q, coin_type_d;
  logic               done_q, done_d;
  logic               short_q, short_d;
  logic               busy_q, busy_d;
  logic               accept;

  assign bal_ready_o = (state_q == StIdle) & ~hrst_i;
  assign accept      = bal_valid_i & bal_ready_o;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    stock_n_d    = stock_n_q;
    stock_d_d    = stock_d_q;
    stock_q_d    = stock_q_q;
    coins_d      = coins_q;
    short_amt_d  = short_amt_q;
    coin_valid_d = coin_valid_q;
    coin_type_d  = coin_type_q;
    done_d       = 1'b0;
    short_d      = 1'b0;

    // Supplier writes only land while idle and not racing a balance accept.
    if (state_q == StIdle && !accept && stock_load_i) begin
      case (stock_sel_i)
        2'd1:    stock_n_d = stock_val_i;
        2'd2:    stock_d_d = stock_val_i;
        2'd3:    stock_q_d = stock_val_i;
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          remaining_d = balance_i;
          coins_d     = 6'd0;
          short_amt_d = 8'd0;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        if (remaining_q == 8'd0) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else if (remaining_q >= QVal && stock_q_q != '0) begin
          coin_type_d  = 2'd3;
          coin_valid_d = 1'b1;
          state_d      = StIssue;
        end else if (remaining_q >= DVal && stock_d_q != '0) begin
          coin_type_d  = 2'd2;
          coin_valid_d = 1'b1;
          state_d      = StIssue;
        end else if (remaining_q >= NVal && stock_n_q != '0) begin
          coin_type_d  = 2'd1;
          coin_valid_d = 1'b1;
          state_d      = StIssue;
        end else begin
          short_d     = 1'b1;
          short_amt_d = remaining_q;
          state_d     = StErr;
        end
      end
      StIssue: begin
        if (coin_ready_i) begin
          case (coin_type_q)
            2'd3: begin
              remaining_d = remaining_q - QVal;
              stock_q_d   = stock_q_q - StockOne;
            end
            2'd2: begin
              remaining_d = remaining_q - DVal;
              stock_d_d   = stock_d_q - StockOne;
            end
            2'd1: begin
              remaining_d = remaining_q - NVal;
              stock_n_d   = stock_n_q - StockOne;
            end
            default: ;
          endcase
          coins_d      = coins_q + 6'd1;
          coin_valid_d = 1'b0;
          coin_type_d  = 2'd0;
          state_d      = StSelect;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (hrst_i) begin
      state_q      <= StIdle;
      remaining_q  <= 8'd0;
      stock_n_q    <= '0;
      stock_d_q    <= '0;
      stock_q_q    <= '0;
      coins_q      <= 6'd0;
      short_amt_q  <= 8'd0;
      coin_valid_q <= 1'b0;
      coin_type_q  <= 2'd0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      stock_n_q    <= stock_n_d;
      stock_d_q    <= stock_d_d;
      stock_q_q    <= stock_q_d;
      coins_q      <= coins_d;
      short_amt_q  <= short_amt_d;
      coin_valid_q <= coin_valid_d;
      coin_type_q  <= coin_type_d;
      done_q       <= done_d;
      short_q      <= short_d;
      busy_q       <= busy_d;
    end
  end

  assign coin_valid_o   = coin_valid_q;
  assign coin_type_o    = coin_type_q;
  assign stock_n_o      = stock_n_q;
  assign stock_d_o      = stock_d_q;
  assign stock_q_o      = stock_q_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign short_o        = short_q;
  assign short_amount_o = short_amt_q;
  assign coins_issued_o = coins_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Scoreboard bench for vm2002_change_dispenser: directed payouts, backpressure and reset.
module tb_vm2002_change_dispenser;

  logic       clk_i = 1'b0;
  logic       hrst_i;
  logic       bal_valid_i;
  logic [7:0] balance_i;
  logic       bal_ready_o;
  logic       coin_valid_o;
  logic [1:0] coin_type_o;
  logic       coin_ready_i;
  logic       stock_load_i;
  logic [1:0] stock_sel_i;
  logic [7:0] stock_val_i;
  logic [7:0] stock_n_o, stock_d_o, stock_q_o;
  logic       busy_o, done_o, short_o;
  logic [7:0] short_amount_o;
  logic [5:0] coins_issued_o;

  vm2002_change_dispenser dut (
    .clk_i         (clk_i),
    .hrst_i        (hrst_i),
    .bal_valid_i   (bal_valid_i),
    .balance_i     (balance_i),
    .bal_ready_o   (bal_ready_o),
    .coin_valid_o  (coin_valid_o),
    .coin_type_o   (coin_type_o),
    .coin_ready_i  (coin_ready_i),
    .stock_load_i  (stock_load_i),
    .stock_sel_i   (stock_sel_i),
    .stock_val_i   (stock_val_i),
    .stock_n_o     (stock_n_o),
    .stock_d_o     (stock_d_o),
    .stock_q_o     (stock_q_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .short_o       (short_o),
    .short_amount_o(short_amount_o),
    .coins_issued_o(coins_issued_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = coin handshake, 1 = done pulse, 2 = short pulse
  typedef struct {
    int kind;
    int val;
    int coins;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic void push(int kind, int val, int coins);
    ev_t e;
    e.kind  = kind;
    e.val   = val;
    e.coins = coins;
    sb.push_back(e);
  endfunction

  task automatic take(int k, int v, int c);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected event kind", k, -1);
    end else begin
      e = sb.pop_front();
      chk("event kind", k, e.kind);
      chk("event value", v, e.val);
      if (k != 0) chk("coins issued", c, e.coins);
    end
  endtask

  always @(negedge clk_i) begin
    if (coin_valid_o && coin_ready_i) take(0, int'(coin_type_o), int'(coins_issued_o));
    if (done_o) take(1, 0, int'(coins_issued_o));
    if (short_o) take(2, int'(short_amount_o), int'(coins_issued_o));
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(int sel, int val);
    stock_load_i = 1'b1;
    stock_sel_i  = 2'(sel);
    stock_val_i  = 8'(val);
    tick();
    stock_load_i = 1'b0;
  endtask

  task automatic stocks(int n, int d, int q);
    load(1, n);
    load(2, d);
    load(3, q);
  endtask

  task automatic chk_stocks(string nm, int n, int d, int q);
    @(negedge clk_i);
    chk({nm, " stock_n"}, int'(stock_n_o), n);
    chk({nm, " stock_d"}, int'(stock_d_o), d);
    chk({nm, " stock_q"}, int'(stock_q_o), q);
  endtask

  task automatic pay(int b);
    bal_valid_i = 1'b1;
    balance_i   = 8'(b);
    tick();
    bal_valid_i = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (!busy_o && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, " reached idle"}, int'(ok), 1);
  endtask

  initial begin
    hrst_i       = 1'b1;
    bal_valid_i  = 1'b0;
    balance_i    = 8'd0;
    coin_ready_i = 1'b0;
    stock_load_i = 1'b0;
    stock_sel_i  = 2'd0;
    stock_val_i  = 8'd0;

    // Reset
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("bal_ready in reset", int'(bal_ready_o), 0);
    @(posedge clk_i);
    #1 hrst_i = 1'b0;
    @(negedge clk_i);
    chk("reset bal_ready", int'(bal_ready_o), 1);
    chk("reset coin_valid", int'(coin_valid_o), 0);
    chk("reset coin_type", int'(coin_type_o), 0);
    chk("reset busy", int'(busy_o), 0);
    chk("reset done", int'(done_o), 0);
    chk("reset short", int'(short_o), 0);
    chk("reset short_amount", int'(short_amount_o), 0);
    chk("reset coins", int'(coins_issued_o), 0);
    chk("reset stocks", int'({stock_n_o, stock_d_o, stock_q_o}), 0);
    @(posedge clk_i);
    #1;
    coin_ready_i = 1'b1;

    // 65 from 10/10/10
    stocks(10, 10, 10);
    push(0, 3, 0); push(0, 3, 0); push(0, 2, 0); push(0, 1, 0); push(1, 0, 4);
    pay(65);
    wait_idle("pay65");
    chk("pay65 coins", int'(coins_issued_o), 4);
    chk_stocks("pay65", 9, 9, 8);

    // 30 with no quarters
    stocks(5, 5, 0);
    push(0, 2, 0); push(0, 2, 0); push(0, 2, 0); push(1, 0, 3);
    pay(30);
    wait_idle("pay30");
    chk_stocks("pay30", 5, 2, 0);

    // 40 with one quarter only
    stocks(0, 0, 1);
    push(0, 3, 0); push(2, 15, 1);
    pay(40);
    wait_idle("pay40");
    chk("pay40 short_amount held", int'(short_amount_o), 15);
    chk("pay40 coins", int'(coins_issued_o), 1);
    chk_stocks("pay40", 0, 0, 0);

    // 7 is not a multiple of 5
    stocks(10, 10, 10);
    push(0, 1, 0); push(2, 2, 1);
    pay(7);
    wait_idle("pay7");
    chk("pay7 short_amount", int'(short_amount_o), 2);

    // zero balance
    push(1, 0, 0);
    pay(0);
    wait_idle("pay0");
    chk("pay0 short_amount cleared", int'(short_amount_o), 0);
    chk_stocks("pay0", 9, 10, 10);

    // Backpressure, latency and load-while-busy
    @(posedge clk_i);
    #1 coin_ready_i = 1'b0;
    push(0, 3, 0); push(1, 0, 1);
    pay(25);
    @(negedge clk_i);
    chk("latency edge1 coin_valid", int'(coin_valid_o), 0);
    @(negedge clk_i);
    chk("latency edge2 coin_valid", int'(coin_valid_o), 1);
    @(posedge clk_i);
    #1;
    stock_load_i = 1'b1;
    stock_sel_i  = 2'd3;
    stock_val_i  = 8'd50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall coin_valid", int'(coin_valid_o), 1);
      chk("stall coin_type", int'(coin_type_o), 3);
      chk("stall bal_ready", int'(bal_ready_o), 0);
    end
    chk("load while busy stock_q", int'(stock_q_o), 10);
    @(posedge clk_i);
    #1;
    stock_load_i = 1'b0;
    coin_ready_i = 1'b1;
    wait_idle("stall25");
    chk_stocks("stall25", 9, 10, 9);

    // Hard reset during ISSUE
    @(posedge clk_i);
    #1 coin_ready_i = 1'b0;
    pay(10);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre-reset coin_valid", int'(coin_valid_o), 1);
    chk("pre-reset coin_type", int'(coin_type_o), 2);
    @(posedge clk_i);
    #1 hrst_i = 1'b1;
    @(posedge clk_i);
    #1 hrst_i = 1'b0;
    @(negedge clk_i);
    chk("hrst coin_valid", int'(coin_valid_o), 0);
    chk("hrst busy", int'(busy_o), 0);
    chk("hrst done", int'(done_o), 0);
    chk("hrst bal_ready", int'(bal_ready_o), 1);
    chk("hrst stocks", int'({stock_n_o, stock_d_o, stock_q_o}), 0);
    @(posedge clk_i);
    #1 coin_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("post-hrst no done", int'(done_o), 0);
    end
    chk("scoreboard drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
